fifo_wr_arbiter: RTL

Round-robin write arbiter sharing one synchronous FIFO write port among NREQ producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST words, then drives the FIFO's `wr_en`/`data_in` and obeys its `full` flag. It sits directly in front of the 8-deep, 4-bit synchronous FIFO and is the only block allowed to drive its write side.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one synchronous FIFO write port among NREQ
//   valid/ready producers. A grant lasts until BURST words have been written,
//   or until the owner drops its valid. Every grant is followed by one IDLE cycle.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   req_valid_i     per-requester data valid
//   req_data_i      packed requester data, requester i at [i*DW +: DW]
//   req_ready_o     per-requester accept (only the owner, only when FIFO not full)
//   fifo_full_i     FIFO full flag
//   fifo_wr_en_o    FIFO write enable
//   fifo_data_in_o  FIFO write data (zero outside a grant)
//   grant_valid_o   a requester currently owns the port
//   grant_id_o      current or most recent owner
//   xfer_count_o    total words written, wraps at 256
module fifo_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 4,
    parameter int unsigned BURST = 2,
    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic               fifo_full_i,
    output logic               fifo_wr_en_o,
    output logic [DW-1:0]      fifo_data_in_o,
    output logic               grant_valid_o,
    output logic [IdW-1:0]     grant_id_o,
    output logic [7:0]         xfer_count_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [IdW-1:0] owner_q, owner_d;
    logic [IdW-1:0] last_grant_q, last_grant_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     xfer_count_q, xfer_count_d;

    logic           in_grant;
    logic           owner_valid;
    logic           xfer;
    logic           sel_found;
    logic [IdW-1:0] sel_idx;
    logic [DW-1:0]  owner_data;

    assign in_grant    = (state_q == StGrant);
    assign owner_valid = req_valid_i[owner_q];
    assign xfer        = in_grant & owner_valid & ~fifo_full_i;

    // Round-robin pick: first valid requester after last_grant, wrapping modulo NREQ.
    always_comb begin
        logic [IdW-1:0] cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdW'((32'(last_grant_q) + k) % NREQ);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == IdW'(i)) begin
                owner_data = req_data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        xfer_count_d = xfer_count_q;
        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d = StGrant;
                    owner_d = sel_idx;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (xfer) begin
                    cnt_d        = cnt_q + 4'd1;
                    xfer_count_d = xfer_count_q + 8'd1;
                end
                // A stalled owner (full FIFO, still valid) keeps the grant indefinitely.
                if ((xfer && (cnt_q == 4'(BURST - 1))) || !owner_valid) begin
                    state_d      = StIdle;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_grant_q <= IdW'(NREQ - 1);
            cnt_q        <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (in_grant && !fifo_full_i) begin
            req_ready_o[owner_q] = 1'b1;
        end
    end

    assign fifo_wr_en_o   = xfer;
    assign fifo_data_in_o = in_grant ? owner_data : '0;
    assign grant_valid_o  = in_grant;
    assign grant_id_o     = owner_q;
    assign xfer_count_o   = xfer_count_q;

endmodule
